// File: rtl/arcade_input_pkg.sv
// Shared constants and types for the arcade input mapper: PS/2 set-2 scan codes,
// MiSTer joystick bit positions, rotation modes and the direction vector.
package arcade_input_pkg;

    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_CTRL  = 8'h14;
    localparam logic [7:0] SC_R     = 8'h2D;
    localparam logic [7:0] SC_F     = 8'h2B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_G     = 8'h34;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_F1    = 8'h05;
    localparam logic [7:0] SC_F2    = 8'h06;
    localparam logic [7:0] SC_5     = 8'h2E;
    localparam logic [7:0] SC_6     = 8'h36;

    localparam int JB_RIGHT    = 0;
    localparam int JB_LEFT     = 1;
    localparam int JB_DOWN     = 2;
    localparam int JB_UP       = 3;
    localparam int JB_FIRE     = 4;
    localparam int JB_START1   = 5;
    localparam int JB_START2   = 6;
    localparam int JB_COIN     = 7;
    localparam int JB_AUTOFIRE = 8;

    typedef enum logic [1:0] {
        ROT_NONE  = 2'd0,
        ROT_CW90  = 2'd1,
        ROT_180   = 2'd2,
        ROT_CCW90 = 2'd3
    } rotate_e;

    typedef enum logic [1:0] {
        COIN_IDLE  = 2'd0,
        COIN_PULSE = 2'd1,
        COIN_GAP   = 2'd2
    } coin_state_e;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
    } dir_t;

    typedef struct packed {
        dir_t p1_dir;
        logic p1_fire_space;
        logic p1_fire_ctrl;
        dir_t p2_dir;
        logic p2_fire;
        logic start1;
        logic start2;
        logic coin1;
        logic coin2;
    } keys_t;

    // Takes joystick bits [3:0] = {U,D,L,R}.
    function automatic dir_t joy_dir(input logic [3:0] j);
        dir_t d;
        d.up    = j[JB_UP];
        d.down  = j[JB_DOWN];
        d.left  = j[JB_LEFT];
        d.right = j[JB_RIGHT];
        return d;
    endfunction

    function automatic dir_t rotate_dir(input dir_t d, input rotate_e r);
        dir_t o;
        case (r)
            ROT_CW90:  o = '{up: d.left,  down: d.right, left: d.down,  right: d.up};
            ROT_180:   o = '{up: d.down,  down: d.up,    left: d.right, right: d.left};
            ROT_CCW90: o = '{up: d.right, down: d.left,  left: d.up,    right: d.down};
            default:   o = d;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/arcade_coin_pulser.sv
// One coin channel: rising-edge request detect, saturating request queue and
// IDLE/PULSE/GAP timer that turns each queued request into a fixed-width pulse.
module arcade_coin_pulser
    import arcade_input_pkg::*;
#(
    parameter int PULSE_CYCLES = 2400000,
    parameter int GAP_CYCLES   = 2400000,
    parameter int QUEUE_MAX    = 3
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic src,
    output logic coin
);

    localparam int TMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(TMAX + 1);
    localparam int QW   = $clog2(QUEUE_MAX + 1);

    coin_state_e   state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [QW-1:0] queue, queue_next;
    logic          src_q;
    logic          req;
    logic          deq;

    assign req  = src & ~src_q;
    assign coin = (state == COIN_PULSE);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        deq        = 1'b0;
        case (state)
            COIN_IDLE: begin
                if (queue != '0) begin
                    deq        = 1'b1;
                    state_next = COIN_PULSE;
                    cnt_next   = '0;
                end
            end
            COIN_PULSE: begin
                if (cnt == CW'(PULSE_CYCLES - 1)) begin
                    state_next = COIN_GAP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            COIN_GAP: begin
                // A waiting request starts straight from the gap so back-to-back
                // pulses are separated by exactly GAP_CYCLES low cycles.
                if (cnt == CW'(GAP_CYCLES - 1)) begin
                    cnt_next = '0;
                    if (queue != '0) begin
                        deq        = 1'b1;
                        state_next = COIN_PULSE;
                    end else begin
                        state_next = COIN_IDLE;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: state_next = COIN_IDLE;
        endcase

        queue_next = queue;
        if (req && !deq) begin
            if (queue != QW'(QUEUE_MAX))
                queue_next = queue + 1'b1;
        end else if (!req && deq) begin
            queue_next = queue - 1'b1;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state <= COIN_IDLE;
            cnt   <= '0;
            queue <= '0;
            src_q <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            queue <= queue_next;
            src_q <= src;
        end
    end

endmodule

// File: rtl/arcade_input_mapper.sv
// Arcade input front end: PS/2 keys + MiSTer joysticks -> rotated per-player controls,
// starts and queued coin pulses. Optional autofire: define ARCADE_INPUT_AUTOFIRE_EN.
module arcade_input_mapper
    import arcade_input_pkg::*;
#(
    parameter int NUM_PLAYERS       = 2,
    parameter int COIN_PULSE_CYCLES = 2400000,
    parameter int COIN_GAP_CYCLES   = 2400000,
    parameter int COIN_QUEUE_MAX    = 3,
    parameter int AUTOFIRE_DIV      = 1200000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    input  logic [1:0]  rotate,
    output logic [3:0]  p1_dir,
    output logic        p1_fire,
    output logic [3:0]  p2_dir,
    output logic        p2_fire,
    output logic        start1,
    output logic        start2,
    output logic        coin1,
    output logic        coin2
);

    logic  primed, toggle_q, pressed;
    keys_t keys, keys_next;
    dir_t  p1_raw, p2_raw, p1_out, p2_out;
    logic  p1_fire_raw, p2_fire_raw;
    logic  [1:0] af_fire;
    logic  [1:0] coin_src, coin_out;
    logic  unused_bits;

    assign pressed     = ps2_key[9];
    assign unused_bits = ^{joystick_0[15:8], joystick_1[15:8]};

    // Key decode feeds the registered outputs directly so a key event shows up
    // on the outputs one cycle later, the same as a joystick change.
    always_comb begin
        keys_next = keys;
        if (primed && (ps2_key[10] != toggle_q)) begin
            case (ps2_key[7:0])
                SC_UP:    keys_next.p1_dir.up    = pressed;
                SC_DOWN:  keys_next.p1_dir.down  = pressed;
                SC_LEFT:  keys_next.p1_dir.left  = pressed;
                SC_RIGHT: keys_next.p1_dir.right = pressed;
                default: begin
                    if (!ps2_key[8]) begin
                        case (ps2_key[7:0])
                            SC_SPACE: keys_next.p1_fire_space = pressed;
                            SC_CTRL:  keys_next.p1_fire_ctrl  = pressed;
                            SC_R:     keys_next.p2_dir.up     = pressed;
                            SC_F:     keys_next.p2_dir.down   = pressed;
                            SC_D:     keys_next.p2_dir.left   = pressed;
                            SC_G:     keys_next.p2_dir.right  = pressed;
                            SC_A:     keys_next.p2_fire       = pressed;
                            SC_F1:    keys_next.start1        = pressed;
                            SC_F2:    keys_next.start2        = pressed;
                            SC_5:     keys_next.coin1         = pressed;
                            SC_6:     keys_next.coin2         = pressed;
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            primed   <= 1'b0;
            toggle_q <= 1'b0;
            keys     <= '0;
        end else begin
            primed   <= 1'b1;
            toggle_q <= ps2_key[10];
            keys     <= keys_next;
        end
    end

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    localparam int AW = $clog2(AUTOFIRE_DIV + 1);

    logic [1:0]         af_btn, af_q, af_wave, af_wave_next;
    logic [1:0][AW-1:0] af_cnt, af_cnt_next;

    assign af_btn  = {joystick_1[JB_AUTOFIRE], joystick_0[JB_AUTOFIRE]};
    assign af_fire = af_btn & af_wave_next;

    // Pressing the button restarts the phase with the wave high, so fire is immediate.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            af_cnt_next[p]  = af_cnt[p] + 1'b1;
            af_wave_next[p] = af_wave[p];
            if (af_btn[p] && !af_q[p]) begin
                af_cnt_next[p]  = '0;
                af_wave_next[p] = 1'b1;
            end else if (af_cnt[p] == AW'(AUTOFIRE_DIV - 1)) begin
                af_cnt_next[p]  = '0;
                af_wave_next[p] = ~af_wave[p];
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            af_q    <= '0;
            af_wave <= '0;
            af_cnt  <= '0;
        end else begin
            af_q    <= af_btn;
            af_wave <= af_wave_next;
            af_cnt  <= af_cnt_next;
        end
    end
`else
    assign af_fire = '0;
`endif

    always_comb begin
        p1_raw      = dir_t'(keys_next.p1_dir | joy_dir(joystick_0[3:0]));
        p2_raw      = dir_t'(keys_next.p2_dir | joy_dir(joystick_1[3:0]));
        p1_fire_raw = keys_next.p1_fire_space | keys_next.p1_fire_ctrl
                    | joystick_0[JB_FIRE] | af_fire[0];
        p2_fire_raw = keys_next.p2_fire | joystick_1[JB_FIRE] | af_fire[1];
        p2_out      = '0;
        if (NUM_PLAYERS == 1) begin
            p1_raw      = dir_t'(p1_raw | p2_raw);
            p1_fire_raw = p1_fire_raw | p2_fire_raw;
            p2_fire_raw = 1'b0;
        end else begin
            p2_out = rotate_dir(p2_raw, rotate_e'(rotate));
        end
        p1_out = rotate_dir(p1_raw, rotate_e'(rotate));
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            p1_dir  <= '0;
            p1_fire <= 1'b0;
            p2_dir  <= '0;
            p2_fire <= 1'b0;
            start1  <= 1'b0;
            start2  <= 1'b0;
        end else begin
            p1_dir  <= p1_out;
            p1_fire <= p1_fire_raw;
            p2_dir  <= p2_out;
            p2_fire <= p2_fire_raw;
            start1  <= keys_next.start1 | joystick_0[JB_START1] | joystick_1[JB_START1];
            start2  <= keys_next.start2 | joystick_0[JB_START2] | joystick_1[JB_START2];
        end
    end

    // A coin button on either stick requests coin1; coin2 comes only from key '6'.
    assign coin_src[0] = keys_next.coin1 | joystick_0[JB_COIN] | joystick_1[JB_COIN];
    assign coin_src[1] = keys_next.coin2;

    for (genvar c = 0; c < 2; c++) begin : g_coin
        arcade_coin_pulser #(
            .PULSE_CYCLES (COIN_PULSE_CYCLES),
            .GAP_CYCLES   (COIN_GAP_CYCLES),
            .QUEUE_MAX    (COIN_QUEUE_MAX)
        ) u_pulser (
            .clk_sys (clk_sys),
            .reset   (reset),
            .src     (coin_src[c]),
            .coin    (coin_out[c])
        );
    end

    assign coin1 = coin_out[0];
    assign coin2 = coin_out[1];

endmodule
